// File: rtl/wb_regfile.sv
// Write-back stage: result select, 32-entry register file with two async read ports,
// and a committed-write counter. Define WB_BYPASS_EN for same-cycle write-through reads.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              RegWriteW,
    input  logic              MemToRegW,
    input  logic [DATA_W-1:0] ReadDataW,
    input  logic [DATA_W-1:0] ALUOutW,
    input  logic [ADDR_W-1:0] WriteRegW,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] ResultW,
    output logic [31:0]       WbCount
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              commit;

    assign ResultW = MemToRegW ? ReadDataW : ALUOutW;

    // Case equality keeps an X enable from being treated as a write in simulation.
    assign commit = (RegWriteW === 1'b1) && (WriteRegW != '0);

    // NOTE: the storage array is reset on purpose: cleared registers are architectural state,
    // so this must stay flops rather than a RAM macro. Sequential state uses <= only.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            WbCount <= '0;
        end else if (commit) begin
            regs[WriteRegW] <= ResultW;
            WbCount         <= WbCount + 32'd1;
        end
    end

    // NOTE: each output gets its default first so every path assigns it and no latch forms.
    always_comb begin
        RD1 = regs[A1];
        if (A1 == '0) begin
            RD1 = '0;
        end
`ifdef WB_BYPASS_EN
        else if (commit && (A1 == WriteRegW)) begin
            RD1 = ResultW;
        end
`endif
    end

    always_comb begin
        RD2 = regs[A2];
        if (A2 == '0) begin
            RD2 = '0;
        end
`ifdef WB_BYPASS_EN
        else if (commit && (A2 == WriteRegW)) begin
            RD2 = ResultW;
        end
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, hand-written corner sequences
// and randomized traffic against an array-based reference model.
module tb_wb_regfile;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        RegWriteW;
    logic        MemToRegW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUOutW;
    logic [4:0]  WriteRegW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] ResultW;
    logic [31:0] WbCount;

    int tests = 0;
    int fails = 0;

    logic [31:0] ref_regs [32];
    logic [31:0] ref_count;

    typedef struct {
        logic        we;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] exp_result;
        logic [31:0] exp_rd1;
        logic [31:0] exp_rd2;
        logic [31:0] exp_count;
    } vec_t;

    vec_t vecs [8];

    wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .RegWriteW (RegWriteW),
        .MemToRegW (MemToRegW),
        .ReadDataW (ReadDataW),
        .ALUOutW   (ALUOutW),
        .WriteRegW (WriteRegW),
        .A1        (A1),
        .A2        (A2),
        .RD1       (RD1),
        .RD2       (RD2),
        .ResultW   (ResultW),
        .WbCount   (WbCount)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] rdata,
                         input logic [31:0] alu, input logic [4:0] wreg,
                         input logic [4:0] a1, input logic [4:0] a2);
        RegWriteW = we;
        MemToRegW = m2r;
        ReadDataW = rdata;
        ALUOutW   = alu;
        WriteRegW = wreg;
        A1        = a1;
        A2        = a2;
    endtask

    function automatic logic [31:0] model_result();
        return MemToRegW ? ReadDataW : ALUOutW;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (RegWriteW && WriteRegW != 5'd0 && a == WriteRegW) return model_result();
`endif
        return ref_regs[a];
    endfunction

    // Applied at the clock edge that the current inputs will commit on.
    task automatic model_edge();
        if (RegWriteW && WriteRegW != 5'd0) begin
            ref_regs[WriteRegW] = model_result();
            ref_count = ref_count + 32'd1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        ref_count = 32'h0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1111, 32'hDEAD_BEEF, 5'd8,  5'd0, 5'd0,
                    32'hDEAD_BEEF, 32'h0, 32'h0, 32'd1};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_CAFE, 32'h1234_5678, 5'd10, 5'd8, 5'd0,
                    32'h0000_CAFE, 32'hDEAD_BEEF, 32'h0, 32'd2};
        vecs[2] = '{1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd10,
                    32'hFFFF_FFFF, 32'h0, 32'h0000_CAFE, 32'd2};
        vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h77, 5'd3, 5'd0, 5'd10,
                    32'h77, 32'h0, 32'h0000_CAFE, 32'd2};
        vecs[4] = '{1'b0, 1'b0, 32'h0, 32'h77, 5'd3, 5'd3, 5'd8,
                    32'h77, 32'h0, 32'hDEAD_BEEF, 32'd2};
        vecs[5] = vecs[4];
        vecs[6] = vecs[4];
        vecs[7] = '{1'b1, 1'b0, 32'h0, 32'h11, 5'd9, 5'd3, 5'd8,
                    32'h11, 32'h0, 32'hDEAD_BEEF, 32'd3};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd31);
        model_reset();
        repeat (2) @(negedge CLK);
        #1;
        check("reset_rd1", RD1, 32'h0);
        check("reset_rd2", RD2, 32'h0);
        check("reset_count", WbCount, 32'h0);
        @(negedge CLK);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            drive(vecs[i].we, vecs[i].m2r, vecs[i].rdata, vecs[i].alu, vecs[i].wreg,
                  vecs[i].a1, vecs[i].a2);
            #1;
            check($sformatf("vec%0d_result", i), ResultW, vecs[i].exp_result);
            check($sformatf("vec%0d_rd1", i), RD1, vecs[i].exp_rd1);
            check($sformatf("vec%0d_rd2", i), RD2, vecs[i].exp_rd2);
            model_edge();
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_count", i), WbCount, vecs[i].exp_count);
        end

        // Register 0 after the edge and disabled writes left reg 3 alone
        @(negedge CLK);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3);
        #1;
        check("reg0_after_write", RD1, 32'h0);
        check("reg3_untouched", RD2, 32'h0);

        // Same-cycle read and write of reg 9 (old value 0x11)
        @(negedge CLK);
        drive(1'b1, 1'b0, 32'h0, 32'h55, 5'd9, 5'd0, 5'd9);
        #1;
`ifdef WB_BYPASS_EN
        check("same_cycle_rd2", RD2, 32'h55);
`else
        check("same_cycle_rd2", RD2, 32'h11);
`endif
        model_edge();
        @(posedge CLK);
        #1;
        check("same_cycle_rd2_after", RD2, 32'h55);
        check("same_cycle_count", WbCount, 32'd4);

        // Counter wrap
        @(negedge CLK);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        force dut.WbCount = 32'hFFFF_FFFF;
        #1;
        release dut.WbCount;
        ref_count = 32'hFFFF_FFFF;
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0ABC, 5'd12, 5'd12, 5'd0);
        model_edge();
        @(posedge CLK);
        #1;
        check("count_wrap", WbCount, 32'h0);
        check("wrap_write_data", RD1, 32'h0000_0ABC);

        // Async reset: reg 5 cleared immediately, pending write to reg 4 discarded
        @(negedge CLK);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5, 5'd5, 5'd0);
        model_edge();
        @(negedge CLK);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_4444, 5'd4, 5'd5, 5'd4);
        #1;
        check("pre_reset_rd1", RD1, 32'h0000_1234);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_rd1", RD1, 32'h0);
        check("async_reset_count", WbCount, 32'h0);
        @(negedge CLK);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd5);
        rst_n = 1'b1;
        #1;
        check("reset_drop_reg4", RD1, 32'h0);
        check("reset_drop_reg5", RD2, 32'h0);
        @(posedge CLK);
        #1;
        check("reset_drop_count", WbCount, 32'h0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wreg;
            logic [4:0] a1;
            logic [4:0] a2;
            @(negedge CLK);
            wreg = 5'($urandom_range(0, 31));
            a1   = ($urandom_range(0, 3) == 0) ? wreg : 5'($urandom_range(0, 31));
            a2   = ($urandom_range(0, 3) == 0) ? wreg : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  wreg, a1, a2);
            #1;
            check("rand_result", ResultW, model_result());
            check("rand_rd1", RD1, model_read(A1));
            check("rand_rd2", RD2, model_read(A2));
            model_edge();
            @(posedge CLK);
            #1;
            check("rand_count", WbCount, ref_count);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
